// File: rtl/core_memory_responder.sv
// Purpose: word-array instruction + data memory that answers a core's fetch and data ports.
// Latency: every accepted request answers exactly READ_LATENCY cycles later, in order, one per cycle per channel.
// Backpressure: both readies drop while a preload is in progress; with MEM_RESPONDER_BACKPRESSURE_EN
//    a 16-bit LFSR also drops them pseudo-randomly (fetch on lfsr[0], data on lfsr[1]).
//
// Ports:
//    clock, reset                 synchronous active-high reset; array contents are not reset
//    fetch_read/_address_out      fetch request in;  fetch_ready out
//    fetch_valid/_data_in/_address_in   fetch response (one-cycle pulse per accepted fetch)
//    memory_read/_write/_byte_en/_address_out/_data_out   data request in;  memory_ready out
//    memory_valid/_data_in/_address_in  data response; write acks carry the merged word
//    load_en/_index/_data         preload port, wins over both channels for that cycle
//    access_error                 sticky flag: read and write requested together
//    fetch_count                  number of accepted fetches, wraps at 2^32
// Optional feature macro: MEM_RESPONDER_BACKPRESSURE_EN (undefined: readies = ~load_en).
module core_memory_responder #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDRESS_BITS = 32,
   parameter int          INDEX_BITS   = 10,
   parameter int          READ_LATENCY = 1,
   parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      fetch_read,
   input  logic [ADDRESS_BITS-1:0]   fetch_address_out,
   output logic                      fetch_ready,
   output logic                      fetch_valid,
   output logic [DATA_WIDTH-1:0]     fetch_data_in,
   output logic [ADDRESS_BITS-1:0]   fetch_address_in,
   input  logic                      memory_read,
   input  logic                      memory_write,
   input  logic [DATA_WIDTH/8-1:0]   memory_byte_en,
   input  logic [ADDRESS_BITS-1:0]   memory_address_out,
   input  logic [DATA_WIDTH-1:0]     memory_data_out,
   output logic                      memory_ready,
   output logic                      memory_valid,
   output logic [DATA_WIDTH-1:0]     memory_data_in,
   output logic [ADDRESS_BITS-1:0]   memory_address_in,
   input  logic                      load_en,
   input  logic [INDEX_BITS-1:0]     load_index,
   input  logic [DATA_WIDTH-1:0]     load_data,
   output logic                      access_error,
   output logic [31:0]               fetch_count
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 1 << INDEX_BITS;

   // A zero seed would lock the LFSR at zero forever.
   if (DATA_WIDTH != 32 || READ_LATENCY < 1 || READ_LATENCY > 8 || STALL_SEED == 16'h0000) begin : g_param_check
      $error("core_memory_responder: unsupported parameter combination");
   end

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    fetch_acc;
   logic                    mem_acc;
   logic                    mem_wr;
   logic [INDEX_BITS-1:0]   fetch_idx;
   logic [INDEX_BITS-1:0]   mem_idx;
   logic [DATA_WIDTH-1:0]   fetch_rdata;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic [DATA_WIDTH-1:0]   mem_merged;

   // Response pipelines: stage 0 is loaded at the accept edge, the last stage drives the outputs.
   logic [READ_LATENCY-1:0] fetch_vld_q, fetch_vld_d;
   logic [ADDRESS_BITS-1:0] fetch_addr_q [READ_LATENCY];
   logic [ADDRESS_BITS-1:0] fetch_addr_d [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   fetch_dat_q  [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   fetch_dat_d  [READ_LATENCY];
   logic [READ_LATENCY-1:0] mem_vld_q, mem_vld_d;
   logic [ADDRESS_BITS-1:0] mem_addr_q [READ_LATENCY];
   logic [ADDRESS_BITS-1:0] mem_addr_d [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   mem_dat_q  [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   mem_dat_d  [READ_LATENCY];

   logic [31:0]             fetch_count_q, fetch_count_d;
   logic                    access_error_q, access_error_d;

   // ------------------------------------------------------------------
   // Ready generation
   // ------------------------------------------------------------------
`ifdef MEM_RESPONDER_BACKPRESSURE_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11, shifting right; feedback enters at bit 15.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= STALL_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign fetch_ready  = ~load_en & ~lfsr_q[0];
   assign memory_ready = ~load_en & ~lfsr_q[1];
`else
   assign fetch_ready  = ~load_en;
   assign memory_ready = ~load_en;
`endif

   // ------------------------------------------------------------------
   // Accept and array access
   // ------------------------------------------------------------------
   // Requests seen while reset is high are ignored so nothing enters the flushed pipelines.
   assign fetch_acc = fetch_read & fetch_ready & ~reset;
   assign mem_acc   = (memory_read | memory_write) & memory_ready & ~reset;
   assign mem_wr    = mem_acc & memory_write;

   // Byte offset and bits above the array depth are dropped: addresses wrap modulo depth.
   assign fetch_idx = fetch_address_out[INDEX_BITS+1:2];
   assign mem_idx   = memory_address_out[INDEX_BITS+1:2];

   // Both reads see the array before this cycle's write lands (read-before-write).
   assign fetch_rdata = mem_q[fetch_idx];
   assign mem_rdata   = mem_q[mem_idx];

   // For reads the merged word equals the stored word, so one path serves both responses.
   always_comb begin
      mem_merged = mem_rdata;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (memory_write && memory_byte_en[b]) begin
            mem_merged[8*b +: 8] = memory_data_out[8*b +: 8];
         end
      end
   end

   // Preload and the data channel never collide: readies are low whenever load_en is high.
   always_ff @(posedge clock) begin
      if (load_en) begin
         mem_q[load_index] <= load_data;
      end else if (mem_wr) begin
         mem_q[mem_idx] <= mem_merged;
      end
   end

   // ------------------------------------------------------------------
   // Response pipelines
   // ------------------------------------------------------------------
   always_comb begin
      fetch_vld_d  = fetch_vld_q;
      fetch_addr_d = fetch_addr_q;
      fetch_dat_d  = fetch_dat_q;
      mem_vld_d    = mem_vld_q;
      mem_addr_d   = mem_addr_q;
      mem_dat_d    = mem_dat_q;

      fetch_vld_d[0]  = fetch_acc;
      fetch_addr_d[0] = fetch_address_out;
      fetch_dat_d[0]  = fetch_rdata;
      mem_vld_d[0]    = mem_acc;
      mem_addr_d[0]   = memory_address_out;
      mem_dat_d[0]    = mem_merged;

      for (int i = 1; i < READ_LATENCY; i++) begin
         fetch_vld_d[i]  = fetch_vld_q[i-1];
         fetch_addr_d[i] = fetch_addr_q[i-1];
         fetch_dat_d[i]  = fetch_dat_q[i-1];
         mem_vld_d[i]    = mem_vld_q[i-1];
         mem_addr_d[i]   = mem_addr_q[i-1];
         mem_dat_d[i]    = mem_dat_q[i-1];
      end
   end

   always_comb begin
      fetch_count_d  = fetch_count_q + {31'd0, fetch_acc};
      access_error_d = access_error_q | (memory_read & memory_write);
   end

   // Control state: clearing the valids on reset drops every in-flight response.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_vld_q    <= '0;
         mem_vld_q      <= '0;
         fetch_count_q  <= '0;
         access_error_q <= 1'b0;
      end else begin
         fetch_vld_q    <= fetch_vld_d;
         mem_vld_q      <= mem_vld_d;
         fetch_count_q  <= fetch_count_d;
         access_error_q <= access_error_d;
      end
   end

   // Payload needs no reset; it is only observed alongside its valid bit.
   always_ff @(posedge clock) begin
      fetch_addr_q <= fetch_addr_d;
      fetch_dat_q  <= fetch_dat_d;
      mem_addr_q   <= mem_addr_d;
      mem_dat_q    <= mem_dat_d;
   end

   assign fetch_valid       = fetch_vld_q[READ_LATENCY-1];
   assign fetch_data_in     = fetch_dat_q[READ_LATENCY-1];
   assign fetch_address_in  = fetch_addr_q[READ_LATENCY-1];
   assign memory_valid      = mem_vld_q[READ_LATENCY-1];
   assign memory_data_in    = mem_dat_q[READ_LATENCY-1];
   assign memory_address_in = mem_addr_q[READ_LATENCY-1];
   assign access_error      = access_error_q;
   assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_core_memory_responder.sv
// Bench for core_memory_responder: three instances (READ_LATENCY 1, 3, 4) share one stimulus stream.
// Directed scenarios use instance 0 (LAT 1) unless the latency itself is under test.
// Outputs are sampled on the falling edge, then new inputs are driven for the next rising edge.
module tb_core_memory_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_read;
   logic [31:0] fetch_address_out;
   logic        memory_read;
   logic        memory_write;
   logic [3:0]  memory_byte_en;
   logic [31:0] memory_address_out;
   logic [31:0] memory_data_out;
   logic        load_en;
   logic [9:0]  load_index;
   logic [31:0] load_data;

   logic        fetch_ready       [3];
   logic        fetch_valid       [3];
   logic [31:0] fetch_data_in     [3];
   logic [31:0] fetch_address_in  [3];
   logic        memory_ready      [3];
   logic        memory_valid      [3];
   logic [31:0] memory_data_in    [3];
   logic [31:0] memory_address_in [3];
   logic        access_error      [3];
   logic [31:0] fetch_count       [3];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          due;
      logic [31:0] addr;
      logic [31:0] data;
   } resp_t;

   resp_t fq[$];
   resp_t mq[$];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      core_memory_responder #(
         .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clock              (clock),
         .reset              (reset),
         .fetch_read         (fetch_read),
         .fetch_address_out  (fetch_address_out),
         .fetch_ready        (fetch_ready[g]),
         .fetch_valid        (fetch_valid[g]),
         .fetch_data_in      (fetch_data_in[g]),
         .fetch_address_in   (fetch_address_in[g]),
         .memory_read        (memory_read),
         .memory_write       (memory_write),
         .memory_byte_en     (memory_byte_en),
         .memory_address_out (memory_address_out),
         .memory_data_out    (memory_data_out),
         .memory_ready       (memory_ready[g]),
         .memory_valid       (memory_valid[g]),
         .memory_data_in     (memory_data_in[g]),
         .memory_address_in  (memory_address_in[g]),
         .load_en            (load_en),
         .load_index         (load_index),
         .load_data          (load_data),
         .access_error       (access_error[g]),
         .fetch_count        (fetch_count[g])
      );
   end

   // Reference sequence: 16-bit Fibonacci LFSR, taps 16,14,13,11, right shift.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   task automatic idle();
      fetch_read         = 1'b0;
      fetch_address_out  = '0;
      memory_read        = 1'b0;
      memory_write       = 1'b0;
      memory_byte_en     = '0;
      memory_address_out = '0;
      memory_data_out    = '0;
      load_en            = 1'b0;
      load_index         = '0;
      load_data          = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      load_en    = 1'b1;
      load_index = 10'(idx);
      load_data  = d;
      #1;
      checks++; if (fetch_ready[0] !== 1'b0 || memory_ready[0] !== 1'b0) begin failures++; $display("FAIL load_ready got=%b%b exp=00", fetch_ready[0], memory_ready[0]); end
      @(negedge clock);
      load_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int g = 0; g < 3; g++) begin
         checks++; if (fetch_valid[g] !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid[%0d] got=%b exp=0", g, fetch_valid[g]); end
         checks++; if (memory_valid[g] !== 1'b0) begin failures++; $display("FAIL rst_memory_valid[%0d] got=%b exp=0", g, memory_valid[g]); end
         checks++; if (access_error[g] !== 1'b0) begin failures++; $display("FAIL rst_access_error[%0d] got=%b exp=0", g, access_error[g]); end
         checks++; if (fetch_count[g] !== 32'd0) begin failures++; $display("FAIL rst_fetch_count[%0d] got=%0d exp=0", g, fetch_count[g]); end
`ifndef MEM_RESPONDER_BACKPRESSURE_EN
         checks++; if (fetch_ready[g] !== 1'b1 || memory_ready[g] !== 1'b1) begin failures++; $display("FAIL rst_ready[%0d] got=%b%b exp=11", g, fetch_ready[g], memory_ready[g]); end
`endif
      end
   endtask

   task automatic test_fetch_basic();
      load(5, 32'h00100593);
      fetch_read        = 1'b1;
      fetch_address_out = 32'h14;
      @(negedge clock);
      fetch_read = 1'b0;
      checks++; if (fetch_valid[0] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", fetch_valid[0]); end
      checks++; if (fetch_data_in[0] !== 32'h00100593) begin failures++; $display("FAIL basic_data got=%h exp=00100593", fetch_data_in[0]); end
      checks++; if (fetch_address_in[0] !== 32'h14) begin failures++; $display("FAIL basic_addr got=%h exp=00000014", fetch_address_in[0]); end
      checks++; if (fetch_valid[1] !== 1'b0) begin failures++; $display("FAIL basic_lat3_early got=%b exp=0", fetch_valid[1]); end
      @(negedge clock);
      checks++; if (fetch_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", fetch_valid[0]); end
      checks++; if (fetch_count[0] !== 32'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", fetch_count[0]); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) load(i, 32'hA0000000 + 32'(i) * 32'h01111111);
      do_reset();
      for (int c = 0; c < 7; c++) begin
         fetch_read        = (c < 3);
         fetch_address_out = 32'(c * 4);
         @(negedge clock);
         begin
            int n;
            logic exp3, exp4;
            n    = c + 1;
            exp3 = (n >= 3 && n <= 5);
            exp4 = (n >= 4 && n <= 6);
            checks++; if (fetch_valid[1] !== exp3) begin failures++; $display("FAIL b2b_lat3_valid cyc%0d got=%b exp=%b", n, fetch_valid[1], exp3); end
            checks++; if (fetch_valid[2] !== exp4) begin failures++; $display("FAIL b2b_lat4_valid cyc%0d got=%b exp=%b", n, fetch_valid[2], exp4); end
            if (exp3) begin
               checks++; if (fetch_data_in[1] !== 32'hA0000000 + 32'(n - 3) * 32'h01111111) begin failures++; $display("FAIL b2b_data cyc%0d got=%h exp=%h", n, fetch_data_in[1], 32'hA0000000 + 32'(n - 3) * 32'h01111111); end
               checks++; if (fetch_address_in[1] !== 32'((n - 3) * 4)) begin failures++; $display("FAIL b2b_addr cyc%0d got=%h exp=%h", n, fetch_address_in[1], 32'((n - 3) * 4)); end
            end
         end
      end
      checks++; if (fetch_count[1] !== 32'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", fetch_count[1]); end
   endtask

   task automatic test_byte_write();
      load(16, 32'h11223344);
      memory_write       = 1'b1;
      memory_byte_en     = 4'b0011;
      memory_address_out = 32'h40;
      memory_data_out    = 32'hDEADBEEF;
      @(negedge clock);
      memory_write = 1'b0;
      checks++; if (memory_valid[0] !== 1'b1) begin failures++; $display("FAIL bw_ack_valid got=%b exp=1", memory_valid[0]); end
      checks++; if (memory_data_in[0] !== 32'h1122BEEF) begin failures++; $display("FAIL bw_ack_data got=%h exp=1122beef", memory_data_in[0]); end
      checks++; if (memory_address_in[0] !== 32'h40) begin failures++; $display("FAIL bw_ack_addr got=%h exp=00000040", memory_address_in[0]); end
      memory_write    = 1'b1;
      memory_byte_en  = 4'b0000;
      memory_data_out = 32'hFFFFFFFF;
      @(negedge clock);
      memory_write = 1'b0;
      checks++; if (memory_valid[0] !== 1'b1 || memory_data_in[0] !== 32'h1122BEEF) begin failures++; $display("FAIL bw_be0_ack got=%b/%h exp=1/1122beef", memory_valid[0], memory_data_in[0]); end
      memory_read        = 1'b1;
      memory_address_out = 32'h42;
      @(negedge clock);
      memory_read = 1'b0;
      checks++; if (memory_valid[0] !== 1'b1 || memory_data_in[0] !== 32'h1122BEEF) begin failures++; $display("FAIL bw_readback got=%b/%h exp=1/1122beef", memory_valid[0], memory_data_in[0]); end
      checks++; if (memory_address_in[0] !== 32'h42) begin failures++; $display("FAIL bw_read_addr got=%h exp=00000042", memory_address_in[0]); end
      @(negedge clock);
      checks++; if (memory_valid[0] !== 1'b0) begin failures++; $display("FAIL bw_pulse got=%b exp=0", memory_valid[0]); end
      checks++; if (access_error[0] !== 1'b0) begin failures++; $display("FAIL bw_no_error got=%b exp=0", access_error[0]); end
   endtask

   task automatic test_rw_error();
      do_reset();
      memory_read        = 1'b1;
      memory_write       = 1'b1;
      memory_byte_en     = 4'b1111;
      memory_address_out = 32'h44;
      memory_data_out    = 32'hCAFEF00D;
      @(negedge clock);
      idle();
      checks++; if (memory_valid[0] !== 1'b1 || memory_data_in[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL rw_ack got=%b/%h exp=1/cafef00d", memory_valid[0], memory_data_in[0]); end
      checks++; if (access_error[0] !== 1'b1) begin failures++; $display("FAIL rw_error_set got=%b exp=1", access_error[0]); end
      @(negedge clock);
      checks++; if (memory_valid[0] !== 1'b0) begin failures++; $display("FAIL rw_single_ack got=%b exp=0", memory_valid[0]); end
      checks++; if (access_error[0] !== 1'b1) begin failures++; $display("FAIL rw_error_sticky got=%b exp=1", access_error[0]); end
      memory_read        = 1'b1;
      memory_address_out = 32'h44;
      @(negedge clock);
      idle();
      checks++; if (memory_valid[0] !== 1'b1 || memory_data_in[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL rw_readback got=%b/%h exp=1/cafef00d", memory_valid[0], memory_data_in[0]); end
      // Fetch into the LAT 4 pipeline, then reset while it is in flight.
      fetch_read        = 1'b1;
      fetch_address_out = 32'h0;
      @(negedge clock);
      fetch_read = 1'b0;
      reset      = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         checks++; if (fetch_valid[2] !== 1'b0) begin failures++; $display("FAIL rst_flight_valid cyc%0d got=%b exp=0", k, fetch_valid[2]); end
      end
      checks++; if (access_error[0] !== 1'b0) begin failures++; $display("FAIL rw_error_cleared got=%b exp=0", access_error[0]); end
      checks++; if (fetch_count[2] !== 32'd0) begin failures++; $display("FAIL rst_flight_count got=%0d exp=0", fetch_count[2]); end
   endtask

   task automatic test_wrap_rbw();
      fetch_read        = 1'b1;
      fetch_address_out = 32'h1000;
      @(negedge clock);
      fetch_address_out = 32'hFFFFF004;
      checks++; if (fetch_valid[0] !== 1'b1 || fetch_data_in[0] !== 32'hA0000000) begin failures++; $display("FAIL wrap_1000 got=%b/%h exp=1/a0000000", fetch_valid[0], fetch_data_in[0]); end
      checks++; if (fetch_address_in[0] !== 32'h1000) begin failures++; $display("FAIL wrap_addr got=%h exp=00001000", fetch_address_in[0]); end
      @(negedge clock);
      fetch_read = 1'b0;
      checks++; if (fetch_valid[0] !== 1'b1 || fetch_data_in[0] !== 32'hA1111111) begin failures++; $display("FAIL wrap_upper got=%b/%h exp=1/a1111111", fetch_valid[0], fetch_data_in[0]); end
      load(3, 32'h33333333);
      fetch_read         = 1'b1;
      fetch_address_out  = 32'hC;
      memory_write       = 1'b1;
      memory_byte_en     = 4'b1111;
      memory_address_out = 32'hC;
      memory_data_out    = 32'h55555555;
      @(negedge clock);
      memory_write = 1'b0;
      checks++; if (fetch_valid[0] !== 1'b1 || fetch_data_in[0] !== 32'h33333333) begin failures++; $display("FAIL rbw_old got=%b/%h exp=1/33333333", fetch_valid[0], fetch_data_in[0]); end
      checks++; if (memory_valid[0] !== 1'b1 || memory_data_in[0] !== 32'h55555555) begin failures++; $display("FAIL rbw_wr_ack got=%b/%h exp=1/55555555", memory_valid[0], memory_data_in[0]); end
      @(negedge clock);
      fetch_read = 1'b0;
      checks++; if (fetch_valid[0] !== 1'b1 || fetch_data_in[0] !== 32'h55555555) begin failures++; $display("FAIL rbw_new got=%b/%h exp=1/55555555", fetch_valid[0], fetch_data_in[0]); end
   endtask

   // Random traffic on the LAT 3 instance against a word model and per-channel expectation queues.
   task automatic test_random();
      logic [31:0] model [16];
      logic [15:0] m_lfsr;
      int          acc_f;
      for (int i = 0; i < 16; i++) begin
         model[i] = $urandom;
         load(i, model[i]);
      end
      do_reset();
      m_lfsr = lfsr_step(16'hACE1);
      acc_f  = 0;
      fq.delete();
      mq.delete();
      for (int it = 0; it < 1006; it++) begin
         logic        exp_fr, exp_mr;
         logic [31:0] m;
         int          fidx, midx, op;
         if (fq.size() > 0 && fq[0].due == it) begin
            checks++; if (fetch_valid[1] !== 1'b1 || fetch_data_in[1] !== fq[0].data || fetch_address_in[1] !== fq[0].addr) begin failures++; $display("FAIL rnd_fetch it%0d got=%b/%h/%h exp=1/%h/%h", it, fetch_valid[1], fetch_address_in[1], fetch_data_in[1], fq[0].addr, fq[0].data); end
            void'(fq.pop_front());
         end else begin
            checks++; if (fetch_valid[1] !== 1'b0) begin failures++; $display("FAIL rnd_fetch_spurious it%0d got=%b exp=0", it, fetch_valid[1]); end
         end
         if (mq.size() > 0 && mq[0].due == it) begin
            checks++; if (memory_valid[1] !== 1'b1 || memory_data_in[1] !== mq[0].data || memory_address_in[1] !== mq[0].addr) begin failures++; $display("FAIL rnd_mem it%0d got=%b/%h/%h exp=1/%h/%h", it, memory_valid[1], memory_address_in[1], memory_data_in[1], mq[0].addr, mq[0].data); end
            void'(mq.pop_front());
         end else begin
            checks++; if (memory_valid[1] !== 1'b0) begin failures++; $display("FAIL rnd_mem_spurious it%0d got=%b exp=0", it, memory_valid[1]); end
         end
`ifdef MEM_RESPONDER_BACKPRESSURE_EN
         exp_fr = ~m_lfsr[0];
         exp_mr = ~m_lfsr[1];
`else
         exp_fr = 1'b1;
         exp_mr = 1'b1;
`endif
         checks++; if (fetch_ready[1] !== exp_fr || memory_ready[1] !== exp_mr) begin failures++; $display("FAIL rnd_ready it%0d got=%b%b exp=%b%b", it, fetch_ready[1], memory_ready[1], exp_fr, exp_mr); end
         idle();
         if (it < 1000) begin
            fidx               = $urandom_range(0, 15);
            midx               = $urandom_range(0, 15);
            op                 = $urandom_range(0, 3);
            fetch_read         = 1'($urandom_range(0, 1));
            fetch_address_out  = ($urandom & 32'hFFFFF003) | (32'(fidx) << 2);
            memory_read        = (op == 1);
            memory_write       = (op == 2);
            memory_byte_en     = 4'($urandom_range(0, 15));
            memory_address_out = ($urandom & 32'hFFFFF003) | (32'(midx) << 2);
            memory_data_out    = $urandom;
            // Fetch model read happens before the same-cycle write is applied.
            if (fetch_read && exp_fr) begin
               fq.push_back('{due: it + 3, addr: fetch_address_out, data: model[fidx]});
               acc_f++;
            end
            if ((memory_read || memory_write) && exp_mr) begin
               m = model[midx];
               if (memory_write) begin
                  for (int b = 0; b < 4; b++) if (memory_byte_en[b]) m[8*b +: 8] = memory_data_out[8*b +: 8];
                  model[midx] = m;
               end
               mq.push_back('{due: it + 3, addr: memory_address_out, data: m});
            end
         end
         @(negedge clock);
         m_lfsr = lfsr_step(m_lfsr);
      end
      checks++; if (fq.size() != 0 || mq.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d/%0d exp=0/0", fq.size(), mq.size()); end
      checks++; if (fetch_count[1] !== 32'(acc_f)) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", fetch_count[1], acc_f); end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
`ifndef MEM_RESPONDER_BACKPRESSURE_EN
      test_fetch_basic();
      test_back_to_back();
      test_byte_write();
      test_rw_error();
      test_wrap_rbw();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
